// File: rtl/dsp_sys_arr_pkg.sv
// Shared types and defaults for the systolic-array datapath.
//   word_t         : data word carried from the row FIFOs into the array
//   feeder_state_t : skew_feeder sequencing states
//   ARR_ROWS/ARR_K : array geometry shared with the array top
//   FIFO_SIZE      : depth of the upstream row FIFOs
package dsp_sys_arr_pkg;

   typedef logic [15:0] word_t;

   localparam int ARR_ROWS  = 4;
   localparam int ARR_K     = 16;
   localparam int FIFO_SIZE = 16;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WAIT   = 2'd1,
      STREAM = 2'd2,
      DONE   = 2'd3
   } feeder_state_t;

endpackage

// File: rtl/feeder_lane.sv
// One row lane of the skew feeder: qualifies the scheduled pop against the
// FIFO empty flag, registers the popped word toward the array row input and
// reports a scheduled pop that found the FIFO empty.
//   i_clk, i_rst  : clock, synchronous active-high reset
//   i_pop_en      : pop scheduled for this row this cycle
//   i_empty       : FIFO empty flag
//   i_dat         : FIFO head word (first-word-fall-through)
//   o_pop         : pop strobe to the FIFO
//   o_arr_dat     : registered word to the array row (zero when not valid)
//   o_arr_vld     : qualifies o_arr_dat
//   o_underflow   : scheduled pop met an empty FIFO (combinational pulse)
module feeder_lane
   import dsp_sys_arr_pkg::*;
(
   input  logic  i_clk,
   input  logic  i_rst,
   input  logic  i_pop_en,
   input  logic  i_empty,
   input  word_t i_dat,
   output logic  o_pop,
   output word_t o_arr_dat,
   output logic  o_arr_vld,
   output logic  o_underflow
);

   word_t r_arr_dat;
   logic  r_arr_vld;
   logic  w_take;

   assign w_take      = i_pop_en & ~i_empty;
   assign o_pop       = w_take;
   assign o_underflow = i_pop_en & i_empty;

   // Non-popping slots are driven as zero so the skew padding is clean.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_arr_dat <= '0;
         r_arr_vld <= 1'b0;
      end else if (w_take) begin
         r_arr_dat <= i_dat;
         r_arr_vld <= 1'b1;
      end else begin
         r_arr_dat <= '0;
         r_arr_vld <= 1'b0;
      end
   end

   assign o_arr_dat = r_arr_dat;
   assign o_arr_vld = r_arr_vld;

endmodule

// File: rtl/skew_feeder.sv
// Drains ROWS FIFOs into the row inputs of a systolic array with a one-cycle
// skew per row: row i pops K words starting K-independent at stream cycle i.
//   clk, rst      : clock, synchronous active-high reset
//   start         : request to stream one tile (honoured only in IDLE)
//   fifo_empty    : per-row FIFO empty
//   fifo_ocp      : per-row FIFO occupancy
//   fifo_dat      : per-row FIFO head word
//   fifo_pop      : per-row pop strobe
//   arr_dat       : registered, skewed data to the array rows
//   arr_vld       : per-row valid for arr_dat
//   busy          : high outside IDLE
//   done          : one-cycle pulse at tile completion
//   err_underflow : sticky, a scheduled pop found an empty FIFO
//
// state  | meaning
// IDLE   | waiting for start
// WAIT   | tile requested, waiting until every FIFO holds at least K words
// STREAM | popping; t counts stream cycles 0..K+ROWS-2
// DONE   | one-cycle completion pulse, last valid word is on arr_dat
module skew_feeder
   import dsp_sys_arr_pkg::*;
#(
   parameter int ROWS = ARR_ROWS,
   parameter int K    = ARR_K,
   parameter int SIZE = FIFO_SIZE
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           start,
   input  logic [ROWS-1:0]                fifo_empty,
   input  logic [ROWS-1:0][$clog2(SIZE):0] fifo_ocp,
   input  word_t [ROWS-1:0]               fifo_dat,
   output logic [ROWS-1:0]                fifo_pop,
   output word_t [ROWS-1:0]               arr_dat,
   output logic [ROWS-1:0]                arr_vld,
   output logic                           busy,
   output logic                           done,
   output logic                           err_underflow
);

   localparam int            TW     = $clog2(K + ROWS);
   localparam logic [TW-1:0] T_LAST = TW'(K + ROWS - 2);

   feeder_state_t r_state;
   feeder_state_t w_state_nxt;
   logic [TW-1:0] r_t;
   logic          r_err;
   logic          w_ocp_ok;
   logic [ROWS-1:0] w_sched;
   logic [ROWS-1:0] w_uf;

   always_comb begin
      w_ocp_ok = 1'b1;
      for (int i = 0; i < ROWS; i++) begin
         if (int'(fifo_ocp[i]) < K) w_ocp_ok = 1'b0;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (start) w_state_nxt = WAIT;
         WAIT:    if (w_ocp_ok) w_state_nxt = STREAM;
         STREAM:  if (r_t == T_LAST) w_state_nxt = DONE;
         DONE:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // t is held at zero outside STREAM, so it is already cleared on entry.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_t     <= '0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_t     <= (r_state == STREAM) ? r_t + TW'(1) : '0;
         r_err   <= r_err | (|w_uf);
      end
   end

   // Pop schedule is gated by rst so an abort stops popping in the same cycle.
   for (genvar g = 0; g < ROWS; g++) begin : g_lane
      assign w_sched[g] = (r_state == STREAM) && !rst &&
                          (int'(r_t) >= g) && (int'(r_t) < g + K);

      feeder_lane u_lane (
         .i_clk       (clk),
         .i_rst       (rst),
         .i_pop_en    (w_sched[g]),
         .i_empty     (fifo_empty[g]),
         .i_dat       (fifo_dat[g]),
         .o_pop       (fifo_pop[g]),
         .o_arr_dat   (arr_dat[g]),
         .o_arr_vld   (arr_vld[g]),
         .o_underflow (w_uf[g])
      );
   end

   assign busy          = (r_state != IDLE);
   assign done          = (r_state == DONE);
   assign err_underflow = r_err;

endmodule

// File: tb/tb_skew_feeder.sv
module tb_skew_feeder;
   import dsp_sys_arr_pkg::*;

   localparam int NR = 4;
   localparam int NK = 4;
   localparam int NS = 16;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 start;
   logic [NR-1:0]        fifo_empty;
   logic [NR-1:0][4:0]   fifo_ocp;
   word_t [NR-1:0]       fifo_dat;
   logic [NR-1:0]        fifo_pop;
   word_t [NR-1:0]       arr_dat;
   logic [NR-1:0]        arr_vld;
   logic                 busy;
   logic                 done;
   logic                 err_underflow;

   word_t fq[NR][$];
   word_t exp_q[NR][$];
   logic [NR-1:0] force_empty;

   int total = 0;
   int bad   = 0;

   skew_feeder #(.ROWS(NR), .K(NK), .SIZE(NS)) dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .fifo_empty    (fifo_empty),
      .fifo_ocp      (fifo_ocp),
      .fifo_dat      (fifo_dat),
      .fifo_pop      (fifo_pop),
      .arr_dat       (arr_dat),
      .arr_vld       (arr_vld),
      .busy          (busy),
      .done          (done),
      .err_underflow (err_underflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic refresh();
      for (int i = 0; i < NR; i++) begin
         fifo_empty[i] = force_empty[i] || (fq[i].size() == 0);
         fifo_ocp[i]   = force_empty[i] ? 5'd0 : 5'(fq[i].size());
         fifo_dat[i]   = fifo_empty[i] ? word_t'(0) : fq[i][0];
      end
   endtask

   task automatic push(input int row, input int val);
      fq[row].push_back(word_t'(val));
      exp_q[row].push_back(word_t'(val));
      refresh();
   endtask

   task automatic preload(input int row, input int base);
      for (int j = 1; j <= NK; j++) push(row, base + j);
   endtask

   task automatic flush_all();
      for (int i = 0; i < NR; i++) begin
         fq[i].delete();
         exp_q[i].delete();
      end
      refresh();
   endtask

   // One clock: FIFO model pops what the DUT strobed, then at the falling
   // edge every valid row output is matched against the scoreboard.
   task automatic tick();
      logic [NR-1:0] pp;
      word_t w;
      #1;
      pp = fifo_pop;
      @(posedge clk);
      #1;
      for (int i = 0; i < NR; i++)
         if (pp[i] && fq[i].size() != 0) void'(fq[i].pop_front());
      refresh();
      @(negedge clk);
      for (int i = 0; i < NR; i++) begin
         if (arr_vld[i]) begin
            if (exp_q[i].size() == 0) chk("sb_extra", 64'(arr_vld[i]), 64'd0);
            else begin
               w = exp_q[i].pop_front();
               chk("sb_dat", 64'(arr_dat[i]), 64'(w));
            end
         end
      end
   endtask

   // Entered at the observation point of stream cycle 0; leaves at the
   // observation point of the first IDLE cycle after DONE.
   task automatic stream_check(input int base3, input bit poke_start);
      int dn;
      logic [NR-1:0] ep, ev;
      dn = 0;
      for (int c = 0; c < NK + NR; c++) begin
         for (int i = 0; i < NR; i++) begin
            ep[i] = (c <= NK + NR - 2) && (c >= i) && (c < i + NK);
            ev[i] = (c >= i + 1) && (c <= i + NK);
         end
         chk("st_pop", 64'(fifo_pop), 64'(ep));
         chk("st_vld", 64'(arr_vld), 64'(ev));
         chk("st_done", 64'(done), 64'(c == NK + NR - 1));
         chk("st_busy", 64'(busy), 64'd1);
         if (c >= NR && c <= NR + NK - 1)
            chk("st_dat3", 64'(arr_dat[NR-1]), 64'(base3 + c - (NR - 1)));
         if (done) dn++;
         if (poke_start && (c == 2 || c == NK + NR - 1)) start = 1'b1;
         tick();
         start = 1'b0;
      end
      chk("st_idle_busy", 64'(busy), 64'd0);
      chk("st_idle_done", 64'(done), 64'd0);
      chk("st_done_cnt", 64'(dn), 64'd1);
      for (int i = 0; i < NR; i++) chk("st_sb_left", 64'(exp_q[i].size()), 64'd0);
   endtask

   task automatic run_tile(input int base3, input bit poke_start);
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("wait_busy", 64'(busy), 64'd1);
      chk("wait_pop", 64'(fifo_pop), 64'd0);
      tick();
      stream_check(base3, poke_start);
   endtask

   initial begin
      rst = 1'b1;
      start = 1'b0;
      force_empty = '0;
      refresh();
      tick();
      tick();
      tick();
      rst = 1'b0;
      tick();
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_vld", 64'(arr_vld), 64'd0);
      chk("rst_dat", 64'(arr_dat), 64'd0);
      chk("rst_err", 64'(err_underflow), 64'd0);
      chk("rst_pop", 64'(fifo_pop), 64'd0);

      // Nominal tile with ignored starts in STREAM and DONE, then a
      // back-to-back tile started in the first IDLE cycle.
      for (int i = 0; i < NR; i++) preload(i, 10 * i);
      run_tile(30, 1'b1);
      for (int i = 0; i < NR; i++) preload(i, 10 * i + 4);
      run_tile(34, 1'b0);

      // Occupancy gate: row 2 short by one word.
      for (int i = 0; i < NR; i++) begin
         if (i == 2) for (int j = 1; j <= NK - 1; j++) push(i, 20 + j);
         else preload(i, 10 * i);
      end
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int c = 0; c < 5; c++) begin
         chk("gate_busy", 64'(busy), 64'd1);
         chk("gate_pop", 64'(fifo_pop), 64'd0);
         chk("gate_vld", 64'(arr_vld), 64'd0);
         tick();
      end
      push(2, 24);
      tick();
      stream_check(30, 1'b0);

      // Underflow: row 1 forced empty in stream cycle 2.
      for (int i = 0; i < NR; i++) preload(i, 10 * i);
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      tick();
      force_empty[1] = 1'b1;
      refresh();
      #1;
      chk("uf_pop", 64'(fifo_pop), 64'b0101);
      chk("uf_err_pre", 64'(err_underflow), 64'd0);
      tick();
      chk("uf_vld1", 64'(arr_vld[1]), 64'd0);
      chk("uf_dat1", 64'(arr_dat[1]), 64'd0);
      chk("uf_err", 64'(err_underflow), 64'd1);
      force_empty[1] = 1'b0;
      refresh();
      for (int c = 4; c <= NK + NR; c++) tick();
      chk("uf_idle_busy", 64'(busy), 64'd0);
      chk("uf_err_sticky", 64'(err_underflow), 64'd1);
      chk("uf_left1", 64'(fq[1].size()), 64'd1);
      flush_all();
      tick();
      chk("uf_err_hold", 64'(err_underflow), 64'd1);

      // Reset mid-stream at t = 3.
      for (int i = 0; i < NR; i++) preload(i, 10 * i);
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int c = 0; c <= 3; c++) tick();
      chk("rs_pop_pre", 64'(fifo_pop), 64'hF);
      rst = 1'b1;
      #1;
      chk("rs_pop", 64'(fifo_pop), 64'd0);
      tick();
      chk("rs_busy", 64'(busy), 64'd0);
      chk("rs_done", 64'(done), 64'd0);
      chk("rs_vld", 64'(arr_vld), 64'd0);
      chk("rs_dat", 64'(arr_dat), 64'd0);
      chk("rs_err", 64'(err_underflow), 64'd0);
      rst = 1'b0;
      tick();
      chk("rs_idle_pop", 64'(fifo_pop), 64'd0);
      chk("rs_idle_busy", 64'(busy), 64'd0);
      flush_all();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/skew_feeder.md
SKEW_FEEDER -- requirements
Module: skew_feeder

Interface
REQ-001 Parameter ROWS, default 4: number of FIFOs drained and systolic-array row inputs driven.
REQ-002 Parameter K, default 16: words popped per row per tile; range 1..FIFO SIZE.
REQ-003 Parameter SIZE, default 16: depth of the upstream FIFOs; sets the ocp width to $clog2(SIZE)+1.
REQ-004 Clock, reset and direction decision: one clock, clk; reset rst is synchronous and active-high.
REQ-005 clk  in  1  rising-edge clock for all state.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 start  in  1  single-cycle request to stream one tile.
REQ-008 fifo_empty  in  ROWS  per-row is_empty from each FIFO.
REQ-009 fifo_ocp  in  ROWS x ($clog2(SIZE)+1)  per-row occupancy.
REQ-010 fifo_dat  in  ROWS x word_t  per-row head word; first-word-fall-through, valid while not empty.
REQ-011 fifo_pop  out  ROWS  per-row pop strobe.
REQ-012 arr_dat  out  ROWS x word_t  registered skewed data to array row inputs.
REQ-013 arr_vld  out  ROWS  per-row valid qualifying arr_dat.
REQ-014 busy  out  1  high in every state except IDLE.
REQ-015 done  out  1  one-cycle pulse marking the tile's completion.
REQ-016 err_underflow  out  1  sticky flag for a scheduled pop that found an empty FIFO.

Function
REQ-017 The FSM states SHALL be IDLE, WAIT, STREAM and DONE, encoded as feeder_state_t.
REQ-018 IDLE -> WAIT on start; start is ignored in every other state.
REQ-019 WAIT -> STREAM on the first cycle in which every fifo_ocp[i] >= K; the stream counter t is cleared to 0 on entry.
REQ-020 In STREAM, fifo_pop[i] SHALL be 1 exactly when i <= t < i+K; t increments every cycle.
REQ-021 STREAM -> DONE when t = K+ROWS-2; that cycle is the last pop cycle (row ROWS-1, word K-1).
REQ-022 DONE lasts one cycle and then returns to IDLE; done = 1 only in DONE.
REQ-023 Data latency: when fifo_pop[i] = 1 in cycle n, arr_dat[i] <= fifo_dat[i] and arr_vld[i] <= 1, visible in cycle n+1.
REQ-024 When fifo_pop[i] = 0, arr_dat[i] <= 0 and arr_vld[i] <= 0 (zero padding for the skew).
REQ-025 The last valid output coincides with done: arr_vld[ROWS-1] = 1 in the DONE cycle.
REQ-026 A tile SHALL occupy exactly K+ROWS-1 STREAM cycles plus 1 DONE cycle.
REQ-027 fifo_pop SHALL be combinational from state and t, and forced to 0 while rst = 1.
REQ-028 If a scheduled pop meets fifo_empty[i] = 1:
  - that pop is suppressed;
  - arr_vld[i] = 0 and arr_dat[i] = 0 for that slot;
  - err_underflow is set; it clears only on rst.
REQ-029 The t counter width is $clog2(K+ROWS); no wrap occurs within a tile.
REQ-030 Back-to-back tiles: start in the DONE cycle is ignored; a new start is accepted from IDLE.

Reset
REQ-031 On rst: state = IDLE, t = 0, arr_dat = 0, arr_vld = 0, done = 0, busy = 0, err_underflow = 0.
REQ-032 rst asserted mid-STREAM aborts the tile with no further pops; FIFO contents already popped are lost.
REQ-033 Reset has priority over start and over every state transition.

Structure
REQ-034 Package dsp_sys_arr_pkg holds word_t (existing) and the new feeder_state_t enum.
REQ-035 ROWS and K defaults SHALL come from package constants shared with the array top.
REQ-036 Sub-module feeder_lane is instantiated once per row:
  - inputs: the pop enable, fifo_dat and fifo_empty;
  - contains the arr_dat/arr_vld registers and the underflow detect.

Verification (ROWS=4, K=4, word_t words)
REQ-037 Nominal tile: FIFO i is preloaded with {10i+1..10i+4}, start pulsed → pop[0] in cycles 0-3, pop[3] in cycles 3-6; arr_dat[3] = 31,32,33,34 in cycles 4-7; done in cycle 7.
REQ-038 Occupancy gate: FIFO2 holds 3 words, start pulsed → the FSM stays in WAIT with no pops; a 4th word is pushed → STREAM begins the next cycle.
REQ-039 Underflow: FIFO1 is forced empty at t = 2 → pop[1] is suppressed; arr_vld[1] = 0 at t = 3; err_underflow = 1 and stays 1 until rst.
REQ-040 Reset mid-stream: rst asserted at t = 3 → in that cycle every pop = 0; the next cycle shows state IDLE and all outputs 0.
REQ-041 Ignored start: start pulsed during STREAM and during DONE → exactly one done pulse; busy falls after DONE.
REQ-042 Back-to-back: a second start issued in the first IDLE cycle after done → a second tile is streamed with identical timing relative to its start.
